riscv_core_reorder_buffer: RTL and testbench

32-entry reorder buffer for the IO2I 2-wide core. Sits beside the issue stage and scoreboard: it allocates ROB slots to up to two issued instructions per cycle, captures results from the A and B writeback stages, and serves operand bypass reads for the scoreboard's `byp_ROB` select. It retires up to two completed entries per cycle in program order. Its commit outputs drive the register-file write ports and the scoreboard's commit inputs.

---
 rtl/riscv_core_reorder_buffer_pkg.sv | 31 +++
 rtl/riscv_core_rob_data_array.sv | 42 ++++
 rtl/riscv_core_reorder_buffer.sv | 181 ++++++++++++++++++
 tb/tb_riscv_core_reorder_buffer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_reorder_buffer_pkg.sv
// riscv_core_rob_defs: definitions shared by the reorder buffer and the scoreboard.
//   ROB_DEPTH / ROB_SLOT_W : entry count and slot-index width
//   rob_commit_t           : one commit-port bundle (val, wen, slot, waddr, wdata)
//   BYP_ROB                : scoreboard operand-select code that routes a bypass from the ROB
package riscv_core_rob_defs;

    localparam int ROB_DEPTH  = 32;
    localparam int ROB_SLOT_W = 5;
    localparam int ROB_REG_W  = 5;
    localparam int ROB_DATA_W = 32;

    localparam logic [3:0] BYP_ROB = 4'd11;

    typedef logic [ROB_SLOT_W-1:0] rob_slot_t;

    typedef struct packed {
        logic                  val;
        logic                  wen;
        rob_slot_t             slot;
        logic [ROB_REG_W-1:0]  waddr;
        logic [ROB_DATA_W-1:0] wdata;
    } rob_commit_t;

    localparam int ROB_COMMIT_W = $bits(rob_commit_t);

    // Slot successor; the 5-bit width gives the 31 -> 0 wrap for free.
    function automatic rob_slot_t slot_inc(input rob_slot_t s);
        return s + rob_slot_t'(1);
    endfunction

endpackage

// File: rtl/riscv_core_rob_data_array.sv
// riscv_core_rob_data_array: 32x32 result storage for the reorder buffer.
//   clk                 : core clock
//   we_a/waddr_a/wdata_a: write port A (wins over B on the same address)
//   we_b/waddr_b/wdata_b: write port B
//   rd_addr[6]/rd_data[6]: combinational read ports (0,1 commit; 2..5 bypass)
// Contents are not reset; reads return the registered array, so a write is
// visible on the read ports from the following cycle.
module riscv_core_rob_data_array
    import riscv_core_rob_defs::*;
(
    input  logic                  clk,
    input  logic                  we_a,
    input  rob_slot_t             waddr_a,
    input  logic [ROB_DATA_W-1:0] wdata_a,
    input  logic                  we_b,
    input  rob_slot_t             waddr_b,
    input  logic [ROB_DATA_W-1:0] wdata_b,
    input  rob_slot_t             rd_addr [6],
    output logic [ROB_DATA_W-1:0] rd_data [6]
);

    logic [ROB_DATA_W-1:0] mem_q [ROB_DEPTH];
    logic [ROB_DATA_W-1:0] mem_d [ROB_DEPTH];

    always_comb begin
        mem_d = mem_q;
        // B first so that A overwrites it on an address collision.
        if (we_b) mem_d[waddr_b] = wdata_b;
        if (we_a) mem_d[waddr_a] = wdata_a;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            rd_data[i] = mem_q[rd_addr[i]];
        end
    end

endmodule

// File: rtl/riscv_core_reorder_buffer.sv
// riscv_core_reorder_buffer: 32-entry reorder buffer for the 2-wide core.
//   clk, reset_n                : clock, synchronous active-low reset
//   alloc_req/wen/waddr_{0,1}   : up to two in-order slot allocations per cycle
//   alloc_slot_{0,1}, rob_full  : granted slots (tail, tail+1) and back-pressure
//   fill_val/slot/data_{A,B}    : writeback results from pipelines A and B
//   rob_commit_*_{1,2}          : up to two in-order retirements per cycle
//   byp_slot_xx / byp_data_xx   : four combinational operand bypass reads
module riscv_core_reorder_buffer
    import riscv_core_rob_defs::*;
#(
    parameter int DEPTH = ROB_DEPTH
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        alloc_req_0,
    input  logic        alloc_req_1,
    input  logic        alloc_wen_0,
    input  logic        alloc_wen_1,
    input  logic [4:0]  alloc_waddr_0,
    input  logic [4:0]  alloc_waddr_1,
    output logic [4:0]  alloc_slot_0,
    output logic [4:0]  alloc_slot_1,
    output logic        rob_full,
    input  logic        fill_val_A,
    input  logic        fill_val_B,
    input  logic [4:0]  fill_slot_A,
    input  logic [4:0]  fill_slot_B,
    input  logic [31:0] fill_data_A,
    input  logic [31:0] fill_data_B,
    output logic        rob_commit_val_1,
    output logic        rob_commit_val_2,
    output logic        rob_commit_wen_1,
    output logic        rob_commit_wen_2,
    output logic [4:0]  rob_commit_slot_1,
    output logic [4:0]  rob_commit_slot_2,
    output logic [4:0]  rob_commit_waddr_1,
    output logic [4:0]  rob_commit_waddr_2,
    output logic [31:0] rob_commit_wdata_1,
    output logic [31:0] rob_commit_wdata_2,
    input  logic [4:0]  byp_slot_00,
    input  logic [4:0]  byp_slot_01,
    input  logic [4:0]  byp_slot_10,
    input  logic [4:0]  byp_slot_11,
    output logic [31:0] byp_data_00,
    output logic [31:0] byp_data_01,
    output logic [31:0] byp_data_10,
    output logic [31:0] byp_data_11
);

    logic [DEPTH-1:0]     valid_q, valid_d, done_q, done_d, wen_q, wen_d;
    logic [ROB_REG_W-1:0] waddr_q [DEPTH];
    logic [ROB_REG_W-1:0] waddr_d [DEPTH];
    rob_slot_t            head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
    logic [5:0]           count_q, count_d;

    logic        full, grant_0, grant_1, commit_1, commit_2, fill_a_ok, fill_b_ok;
    logic [1:0]  n_alloc, n_commit;
    rob_slot_t   rd_addr [6];
    logic [31:0] rd_data [6];
    rob_commit_t cm_1, cm_2;

    assign head_p1 = slot_inc(head_q);
    assign tail_p1 = slot_inc(tail_q);
    assign full    = (count_q >= 6'd31);

    // Requests while full are dropped outright; ir1 rides only with ir0.
    assign grant_0 = alloc_req_0 && !full;
    assign grant_1 = grant_0 && alloc_req_1;

    assign commit_1 = valid_q[head_q] && done_q[head_q];
    assign commit_2 = commit_1 && valid_q[head_p1] && done_q[head_p1];

    assign fill_a_ok = fill_val_A && valid_q[fill_slot_A];
    assign fill_b_ok = fill_val_B && valid_q[fill_slot_B]
                       && !(fill_a_ok && (fill_slot_A == fill_slot_B));

    assign n_alloc  = {1'b0, grant_0} + {1'b0, grant_1};
    assign n_commit = {1'b0, commit_1} + {1'b0, commit_2};

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        wen_d   = wen_q;
        waddr_d = waddr_q;
        if (fill_a_ok) done_d[fill_slot_A] = 1'b1;
        if (fill_b_ok) done_d[fill_slot_B] = 1'b1;
        if (commit_1) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
        end
        if (commit_2) begin
            valid_d[head_p1] = 1'b0;
            done_d[head_p1]  = 1'b0;
        end
        if (grant_0) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            wen_d[tail_q]   = alloc_wen_0;
            waddr_d[tail_q] = alloc_waddr_0;
        end
        if (grant_1) begin
            valid_d[tail_p1] = 1'b1;
            done_d[tail_p1]  = 1'b0;
            wen_d[tail_p1]   = alloc_wen_1;
            waddr_d[tail_p1] = alloc_waddr_1;
        end
        head_d  = head_q + {3'b000, n_commit};
        tail_d  = tail_q + {3'b000, n_alloc};
        count_d = count_q + {4'b0000, n_alloc} - {4'b0000, n_commit};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        wen_q   <= wen_d;
        waddr_q <= waddr_d;
    end

    assign rd_addr[0] = head_q;
    assign rd_addr[1] = head_p1;
    assign rd_addr[2] = byp_slot_00;
    assign rd_addr[3] = byp_slot_01;
    assign rd_addr[4] = byp_slot_10;
    assign rd_addr[5] = byp_slot_11;

    riscv_core_rob_data_array u_data (
        .clk     (clk),
        .we_a    (fill_a_ok),
        .waddr_a (fill_slot_A),
        .wdata_a (fill_data_A),
        .we_b    (fill_b_ok),
        .waddr_b (fill_slot_B),
        .wdata_b (fill_data_B),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Commit bundles are zeroed when idle so the register file sees clean ports.
    always_comb begin
        cm_1 = '0;
        cm_2 = '0;
        if (commit_1) cm_1 = '{val: 1'b1, wen: wen_q[head_q], slot: head_q,
                               waddr: waddr_q[head_q], wdata: rd_data[0]};
        if (commit_2) cm_2 = '{val: 1'b1, wen: wen_q[head_p1], slot: head_p1,
                               waddr: waddr_q[head_p1], wdata: rd_data[1]};
    end

    assign alloc_slot_0       = tail_q;
    assign alloc_slot_1       = tail_p1;
    assign rob_full           = full;
    assign rob_commit_val_1   = cm_1.val;
    assign rob_commit_wen_1   = cm_1.wen;
    assign rob_commit_slot_1  = cm_1.slot;
    assign rob_commit_waddr_1 = cm_1.waddr;
    assign rob_commit_wdata_1 = cm_1.wdata;
    assign rob_commit_val_2   = cm_2.val;
    assign rob_commit_wen_2   = cm_2.wen;
    assign rob_commit_slot_2  = cm_2.slot;
    assign rob_commit_waddr_2 = cm_2.waddr;
    assign rob_commit_wdata_2 = cm_2.wdata;
    assign byp_data_00        = rd_data[2];
    assign byp_data_01        = rd_data[3];
    assign byp_data_10        = rd_data[4];
    assign byp_data_11        = rd_data[5];

endmodule

// File: tb/tb_riscv_core_reorder_buffer.sv
// Self-checking bench for riscv_core_reorder_buffer: a table of per-cycle
// vectors, then hand-written sequences for full, wrap, bypass timing and reset.
// Allocations push the expected retirement into a queue; commits pop it.
module tb_riscv_core_reorder_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alloc_req_0, alloc_req_1, alloc_wen_0, alloc_wen_1;
    logic [4:0]  alloc_waddr_0, alloc_waddr_1, alloc_slot_0, alloc_slot_1;
    logic        rob_full;
    logic        fill_val_A, fill_val_B;
    logic [4:0]  fill_slot_A, fill_slot_B;
    logic [31:0] fill_data_A, fill_data_B;
    logic        rob_commit_val_1, rob_commit_val_2, rob_commit_wen_1, rob_commit_wen_2;
    logic [4:0]  rob_commit_slot_1, rob_commit_slot_2, rob_commit_waddr_1, rob_commit_waddr_2;
    logic [31:0] rob_commit_wdata_1, rob_commit_wdata_2;
    logic [4:0]  byp_slot_00, byp_slot_01, byp_slot_10, byp_slot_11;
    logic [31:0] byp_data_00, byp_data_01, byp_data_10, byp_data_11;

    always #5 clk = ~clk;

    riscv_core_reorder_buffer dut (
        .clk(clk), .reset_n(reset_n),
        .alloc_req_0(alloc_req_0), .alloc_req_1(alloc_req_1),
        .alloc_wen_0(alloc_wen_0), .alloc_wen_1(alloc_wen_1),
        .alloc_waddr_0(alloc_waddr_0), .alloc_waddr_1(alloc_waddr_1),
        .alloc_slot_0(alloc_slot_0), .alloc_slot_1(alloc_slot_1), .rob_full(rob_full),
        .fill_val_A(fill_val_A), .fill_val_B(fill_val_B),
        .fill_slot_A(fill_slot_A), .fill_slot_B(fill_slot_B),
        .fill_data_A(fill_data_A), .fill_data_B(fill_data_B),
        .rob_commit_val_1(rob_commit_val_1), .rob_commit_val_2(rob_commit_val_2),
        .rob_commit_wen_1(rob_commit_wen_1), .rob_commit_wen_2(rob_commit_wen_2),
        .rob_commit_slot_1(rob_commit_slot_1), .rob_commit_slot_2(rob_commit_slot_2),
        .rob_commit_waddr_1(rob_commit_waddr_1), .rob_commit_waddr_2(rob_commit_waddr_2),
        .rob_commit_wdata_1(rob_commit_wdata_1), .rob_commit_wdata_2(rob_commit_wdata_2),
        .byp_slot_00(byp_slot_00), .byp_slot_01(byp_slot_01),
        .byp_slot_10(byp_slot_10), .byp_slot_11(byp_slot_11),
        .byp_data_00(byp_data_00), .byp_data_01(byp_data_01),
        .byp_data_10(byp_data_10), .byp_data_11(byp_data_11)
    );

    typedef struct {
        logic [4:0] slot;
        logic       wen;
        logic [4:0] waddr;
    } sb_t;

    typedef struct {
        int unsigned a0, a1, w0, w1, wa0, wa1;
        int unsigned fa, fb, sa, sb, da, db;
        int unsigned exp_s0, exp_nc, byp_chk, byp_s, exp_byp;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    sb_t         sb_q[$];
    logic [31:0] exp_data [32];
    logic [4:0]  exp_tail;
    vec_t        vt [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cmp_commit(input string nm, input sb_t e, input logic [4:0] s,
                              input logic w, input logic [4:0] a, input logic [31:0] d);
        chk({nm, "_slot"}, 32'(s), 32'(e.slot));
        chk({nm, "_wen"}, 32'(w), 32'(e.wen));
        if (e.wen) begin
            chk({nm, "_waddr"}, 32'(a), 32'(e.waddr));
            chk({nm, "_wdata"}, d, exp_data[e.slot]);
        end
    endtask

    task automatic mon();
        sb_t e;
        if (rob_commit_val_2) chk("commit2_without_commit1", 32'(rob_commit_val_1), 32'd1);
        if (rob_commit_val_2 && rob_commit_slot_1 == 5'd31)
            chk("wrap_commit2_slot", 32'(rob_commit_slot_2), 32'd0);
        if (rob_commit_val_1) begin
            if (sb_q.size() == 0) chk("commit1_spurious", 32'(rob_commit_val_1), 32'd0);
            else begin
                e = sb_q.pop_front();
                cmp_commit("c1", e, rob_commit_slot_1, rob_commit_wen_1, rob_commit_waddr_1, rob_commit_wdata_1);
            end
        end
        if (rob_commit_val_2) begin
            if (sb_q.size() == 0) chk("commit2_spurious", 32'(rob_commit_val_2), 32'd0);
            else begin
                e = sb_q.pop_front();
                cmp_commit("c2", e, rob_commit_slot_2, rob_commit_wen_2, rob_commit_waddr_2, rob_commit_wdata_2);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        mon();
    endtask

    task automatic idle();
        alloc_req_0 = 0; alloc_req_1 = 0; alloc_wen_0 = 0; alloc_wen_1 = 0;
        alloc_waddr_0 = 0; alloc_waddr_1 = 0;
        fill_val_A = 0; fill_val_B = 0; fill_slot_A = 0; fill_slot_B = 0;
        fill_data_A = 0; fill_data_B = 0;
    endtask

    task automatic do_alloc(input bit two, input logic w0, input logic [4:0] a0,
                            input logic w1, input logic [4:0] a1);
        sb_t e;
        chk("alloc_slot_0", 32'(alloc_slot_0), 32'(exp_tail));
        alloc_req_0 = 1; alloc_wen_0 = w0; alloc_waddr_0 = a0;
        e.slot = exp_tail; e.wen = w0; e.waddr = a0;
        sb_q.push_back(e);
        exp_tail++;
        if (two) begin
            chk("alloc_slot_1", 32'(alloc_slot_1), 32'(exp_tail));
            alloc_req_1 = 1; alloc_wen_1 = w1; alloc_waddr_1 = a1;
            e.slot = exp_tail; e.wen = w1; e.waddr = a1;
            sb_q.push_back(e);
            exp_tail++;
        end
    endtask

    task automatic fill_a(input logic [4:0] s, input logic [31:0] d);
        fill_val_A = 1; fill_slot_A = s; fill_data_A = d; exp_data[s] = d;
    endtask

    task automatic fill_b(input logic [4:0] s, input logic [31:0] d);
        fill_val_B = 1; fill_slot_B = s; fill_data_B = d; exp_data[s] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0]  s;
        logic [31:0] old;
        int          k;

        //        a0 a1 w0 w1 wa0 wa1 fa fb sa sb  da       db       s0 nc bc bs byp
        vt[0] = '{1, 1, 1, 1, 5,  6,  0, 0, 0, 0, 0,       0,       0, 0, 0, 0, 0};
        vt[1] = '{0, 0, 0, 0, 0,  0,  0, 1, 0, 1, 0,       'hBEEF,  2, 0, 0, 0, 0};
        vt[2] = '{0, 0, 0, 0, 0,  0,  1, 0, 0, 0, 'h1234,  0,       2, 0, 0, 0, 0};
        vt[3] = '{0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0,       0,       2, 2, 1, 1, 'hBEEF};
        vt[4] = '{1, 1, 1, 0, 7,  9,  0, 0, 0, 0, 0,       0,       2, 0, 0, 0, 0};
        vt[5] = '{0, 0, 0, 0, 0,  0,  1, 0, 3, 0, 'hCAFE,  0,       4, 0, 1, 0, 'h1234};
        vt[6] = '{0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0,       0,       4, 0, 1, 3, 'hCAFE};
        vt[7] = '{0, 0, 0, 0, 0,  0,  0, 1, 0, 2, 0,       'h7777,  4, 0, 0, 0, 0};
        vt[8] = '{0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0,       0,       4, 2, 0, 0, 0};

        reset_n = 0;
        idle();
        byp_slot_00 = 0; byp_slot_01 = 0; byp_slot_10 = 0; byp_slot_11 = 0;
        exp_tail = 0;
        for (int i = 0; i < 32; i++) exp_data[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        chk("rst_full", 32'(rob_full), 32'd0);
        chk("rst_val_1", 32'(rob_commit_val_1), 32'd0);
        chk("rst_val_2", 32'(rob_commit_val_2), 32'd0);
        chk("rst_wen_1", 32'(rob_commit_wen_1), 32'd0);
        chk("rst_slot_2", 32'(rob_commit_slot_2), 32'd0);
        chk("rst_waddr_1", 32'(rob_commit_waddr_1), 32'd0);
        chk("rst_wdata_1", rob_commit_wdata_1, 32'd0);
        chk("rst_wdata_2", rob_commit_wdata_2, 32'd0);
        chk("rst_alloc_slot_0", 32'(alloc_slot_0), 32'd0);
        chk("rst_alloc_slot_1", 32'(alloc_slot_1), 32'd1);
        reset_n = 1;

        // Table: dual commit with B-before-A fill, then out-of-order fill.
        for (int i = 0; i < 9; i++) begin
            idle();
            chk("row_slot0", 32'(alloc_slot_0), vt[i].exp_s0);
            chk("row_slot1", 32'(alloc_slot_1), 32'(5'(vt[i].exp_s0 + 1)));
            chk("row_ncommit", 32'(rob_commit_val_1) + 32'(rob_commit_val_2), vt[i].exp_nc);
            chk("row_full", 32'(rob_full), 32'd0);
            if (vt[i].a0 != 0)
                do_alloc(vt[i].a1 != 0, vt[i].w0[0], 5'(vt[i].wa0), vt[i].w1[0], 5'(vt[i].wa1));
            if (vt[i].fa != 0) fill_a(5'(vt[i].sa), vt[i].da);
            if (vt[i].fb != 0) fill_b(5'(vt[i].sb), vt[i].db);
            byp_slot_00 = 5'(vt[i].byp_s);
            #1;
            if (vt[i].byp_chk != 0) chk("row_byp", byp_data_00, vt[i].exp_byp);
            tick();
        end

        // Fill the buffer to 31 entries (head = tail = 4 here).
        for (int i = 0; i < 15; i++) begin
            idle();
            do_alloc(1, 1, 5'(i), 1, 5'(i + 1));
            tick();
        end
        idle();
        chk("full_at_30", 32'(rob_full), 32'd0);
        do_alloc(0, 1, 5'd20, 0, 5'd0);
        tick();
        idle();
        chk("full_at_31", 32'(rob_full), 32'd1);
        alloc_req_0 = 1; alloc_req_1 = 1; alloc_wen_0 = 1; alloc_wen_1 = 1;
        tick();
        chk("full_tail_hold_1", 32'(alloc_slot_0), 32'(exp_tail));
        tick();
        chk("full_tail_hold_2", 32'(alloc_slot_0), 32'(exp_tail));
        chk("full_still_set", 32'(rob_full), 32'd1);
        idle();
        fill_a(5'd4, 32'hA0A0_0004);
        tick();
        idle();
        chk("full_during_commit", 32'(rob_full), 32'd1);
        tick();
        chk("full_release", 32'(rob_full), 32'd0);

        for (int j = 0; j < 15; j++) begin
            idle();
            fill_a(5'(5 + 2 * j), 32'hD000_0000 | 32'(2 * j));
            fill_b(5'(6 + 2 * j), 32'hE000_0000 | 32'(2 * j + 1));
            tick();
        end
        idle();
        k = 0;
        while (sb_q.size() != 0 && k < 64) begin
            tick();
            k++;
        end
        chk("drain_pending", 32'(sb_q.size()), 32'd0);

        // 48 alloc/fill/commit pairs starting at slot 3: wraps through (31,0).
        for (int p = 0; p < 48; p++) begin
            idle();
            s = exp_tail;
            do_alloc(1, 1, 5'(p), 1, 5'(p + 7));
            tick();
            idle();
            fill_a(s, $urandom);
            fill_b(5'(s + 1), $urandom);
            tick();
            idle();
            tick();
        end
        chk("wrap_queue_empty", 32'(sb_q.size()), 32'd0);

        // Bypass: fill of slot 3 is not visible until the next cycle.
        idle();
        old = exp_data[3];
        do_alloc(0, 1, 5'd10, 0, 5'd0);
        tick();
        idle();
        fill_a(5'd3, 32'h0000_CAFE);
        byp_slot_00 = 5'd3; byp_slot_01 = 5'd1; byp_slot_10 = 5'd2; byp_slot_11 = 5'd31;
        #1;
        chk("byp_fill_cycle", byp_data_00, old);
        chk("byp_01", byp_data_01, exp_data[1]);
        chk("byp_10", byp_data_10, exp_data[2]);
        chk("byp_11", byp_data_11, exp_data[31]);
        tick();
        idle();
        chk("byp_next_cycle", byp_data_00, 32'h0000_CAFE);
        tick();

        // Reset with five entries in flight.
        do_alloc(1, 1, 5'd1, 1, 5'd2);
        tick();
        idle();
        do_alloc(1, 1, 5'd3, 1, 5'd4);
        tick();
        idle();
        do_alloc(0, 1, 5'd5, 0, 5'd0);
        tick();
        idle();
        fill_a(5'd5, 32'h5555_0005); fill_b(5'd6, 32'h5555_0006);
        tick();
        idle();
        fill_a(5'd7, 32'h5555_0007); fill_b(5'd8, 32'h5555_0008);
        tick();
        idle();
        fill_a(5'd4, 32'h5555_0004);
        reset_n = 0;
        tick();
        chk("midrst_val_1", 32'(rob_commit_val_1), 32'd0);
        chk("midrst_val_2", 32'(rob_commit_val_2), 32'd0);
        chk("midrst_wdata_1", rob_commit_wdata_1, 32'd0);
        chk("midrst_full", 32'(rob_full), 32'd0);
        chk("midrst_slot_0", 32'(alloc_slot_0), 32'd0);
        chk("midrst_slot_1", 32'(alloc_slot_1), 32'd1);
        idle();
        reset_n = 1;
        sb_q.delete();
        exp_tail = 0;
        for (int i = 0; i < 15; i++) begin
            idle();
            do_alloc(1, 0, 5'd0, 0, 5'd0);
            tick();
        end
        idle();
        chk("postrst_full_at_30", 32'(rob_full), 32'd0);
        do_alloc(0, 0, 5'd0, 0, 5'd0);
        tick();
        idle();
        chk("postrst_full_at_31", 32'(rob_full), 32'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
